mixer_duc_nco: RTL



---
 rtl/mixer_duc_nco.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mixer_duc_nco.sv
// rtl/mixer_duc_nco.sv - phase-accumulator NCO with 8-bit signed cos/sin carrier and valid/ready output
//
// Purpose: generates the carrier pair for the DUC mixer's 16x8 multipliers.
// The top 8 bits of a free-running phase accumulator index a sine/cosine
// lookup built from a 65-entry quarter-wave table. A 2-stage pipeline
// (index stage, output stage) advances only when the output slot is empty
// or being consumed, so no carrier sample is dropped or repeated.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   ce             clock enable; low freezes every register
//   phase_inc      unsigned phase increment per sample
//   phase_inc_load captures phase_inc into the increment register
//   phase_clr      clears the phase accumulator
//   m_valid        cos_out/sin_out hold a valid sample
//   m_ready        consumer accepts the current sample
//   cos_out        signed round(127*cos(2*pi*k/256))
//   sin_out        signed round(127*sin(2*pi*k/256))
//
// PHASE_WIDTH must be at least 8.

module mixer_duc_nco #(
  parameter int PHASE_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [PHASE_WIDTH-1:0] phase_inc,
  input  logic                   phase_inc_load,
  input  logic                   phase_clr,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic signed [7:0]      cos_out,
  output logic signed [7:0]      sin_out
);

  // Magnitude of round(127*sin(2*pi*idx/256)) for idx in 0..64.
  function automatic logic [6:0] quarter_sin(input logic [6:0] idx);
    logic [6:0] v;
    case (idx)
      7'd0:  v = 7'd0;
      7'd1:  v = 7'd3;
      7'd2:  v = 7'd6;
      7'd3:  v = 7'd9;
      7'd4:  v = 7'd12;
      7'd5:  v = 7'd16;
      7'd6:  v = 7'd19;
      7'd7:  v = 7'd22;
      7'd8:  v = 7'd25;
      7'd9:  v = 7'd28;
      7'd10: v = 7'd31;
      7'd11: v = 7'd34;
      7'd12: v = 7'd37;
      7'd13: v = 7'd40;
      7'd14: v = 7'd43;
      7'd15: v = 7'd46;
      7'd16: v = 7'd49;
      7'd17: v = 7'd51;
      7'd18: v = 7'd54;
      7'd19: v = 7'd57;
      7'd20: v = 7'd60;
      7'd21: v = 7'd63;
      7'd22: v = 7'd65;
      7'd23: v = 7'd68;
      7'd24: v = 7'd71;
      7'd25: v = 7'd73;
      7'd26: v = 7'd76;
      7'd27: v = 7'd78;
      7'd28: v = 7'd81;
      7'd29: v = 7'd83;
      7'd30: v = 7'd85;
      7'd31: v = 7'd88;
      7'd32: v = 7'd90;
      7'd33: v = 7'd92;
      7'd34: v = 7'd94;
      7'd35: v = 7'd96;
      7'd36: v = 7'd98;
      7'd37: v = 7'd100;
      7'd38: v = 7'd102;
      7'd39: v = 7'd104;
      7'd40: v = 7'd106;
      7'd41: v = 7'd107;
      7'd42: v = 7'd109;
      7'd43: v = 7'd111;
      7'd44: v = 7'd112;
      7'd45: v = 7'd113;
      7'd46: v = 7'd115;
      7'd47: v = 7'd116;
      7'd48: v = 7'd117;
      7'd49: v = 7'd118;
      7'd50: v = 7'd120;
      7'd51: v = 7'd121;
      7'd52: v = 7'd122;
      7'd53: v = 7'd122;
      7'd54: v = 7'd123;
      7'd55: v = 7'd124;
      7'd56: v = 7'd125;
      7'd57: v = 7'd125;
      7'd58: v = 7'd126;
      7'd59: v = 7'd126;
      7'd60: v = 7'd126;
      7'd61: v = 7'd127;
      7'd62: v = 7'd127;
      7'd63: v = 7'd127;
      7'd64: v = 7'd127;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  // Full-circle sine from the quarter table: quadrants 1 and 3 mirror the
  // index (64 - r), quadrants 2 and 3 negate. Mirroring uses 64 - r rather
  // than 63 - r so the table's endpoints (0 and 127) land exactly on the axes.
  function automatic logic signed [7:0] sin_lookup(input logic [7:0] k);
    logic [6:0] idx;
    logic [6:0] mag;
    if (k[6]) begin
      idx = 7'd64 - {1'b0, k[5:0]};
    end else begin
      idx = {1'b0, k[5:0]};
    end
    mag = quarter_sin(idx);
    if (k[7]) begin
      return -$signed({1'b0, mag});
    end else begin
      return $signed({1'b0, mag});
    end
  endfunction

  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] inc_q, inc_d;
  logic [7:0]             k1_q, k1_d;
  logic                   v1_q, v1_d;
  logic                   m_valid_q, m_valid_d;
  logic signed [7:0]      cos_q, cos_d;
  logic signed [7:0]      sin_q, sin_d;
  logic                   adv;

  // The whole pipeline moves together: it advances when the output slot is
  // empty or is being taken this cycle. m_valid comes from a flop, so it
  // never depends combinationally on m_ready.
  assign adv = ce && (!m_valid_q || m_ready);

  always_comb begin
    acc_d     = acc_q;
    inc_d     = inc_q;
    k1_d      = k1_q;
    v1_d      = v1_q;
    m_valid_d = m_valid_q;
    cos_d     = cos_q;
    sin_d     = sin_q;

    if (adv) begin
      k1_d      = acc_q[PHASE_WIDTH-1 -: 8];
      v1_d      = 1'b1;
      cos_d     = sin_lookup(k1_q + 8'd64);
      sin_d     = sin_lookup(k1_q);
      m_valid_d = v1_q;
      acc_d     = acc_q + inc_q;
    end

    // Clear wins over the accumulate so the next sample taken is exactly k=0.
    if (ce && phase_clr) begin
      acc_d = '0;
    end

    // A freshly loaded increment is only seen by the accumulate on later
    // cycles, because this cycle's sum already used inc_q.
    if (ce && phase_inc_load) begin
      inc_d = phase_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      inc_q     <= '0;
      k1_q      <= 8'd0;
      v1_q      <= 1'b0;
      m_valid_q <= 1'b0;
      cos_q     <= 8'sd0;
      sin_q     <= 8'sd0;
    end else begin
      acc_q     <= acc_d;
      inc_q     <= inc_d;
      k1_q      <= k1_d;
      v1_q      <= v1_d;
      m_valid_q <= m_valid_d;
      cos_q     <= cos_d;
      sin_q     <= sin_d;
    end
  end

  assign m_valid = m_valid_q;
  assign cos_out = cos_q;
  assign sin_out = sin_q;

endmodule
